// File: rtl/serial_frame_decoder_if.sv
// Output handshake of the serial frame decoder.
// Carries one tagged sample word per accepted transfer.
interface serial_frame_decoder_if;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [1:0]  out_phase;

   modport master (
      output out_valid,
      output out_data,
      output out_phase,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_phase,
      output out_ready
   );
endinterface

// File: rtl/serial_frame_decoder.sv
// Sync-hunting frame slicer for the shift-register window,
// with a small fall-through FIFO toward the analyzer core.
module serial_frame_decoder #(
   parameter logic [7:0] SYNC_BYTE  = 8'hA5,
   parameter int         NUM_WORDS  = 3,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [8:1]                    window_in,
   serial_frame_decoder_if.master        frm,
   output logic                          locked,
   output logic                          sync_err,
   output logic                          overflow
);

   localparam int         AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [1:0] LAST = 2'(NUM_WORDS - 1);
   localparam logic [AW:0] FULL  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0] CNT_1 = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_1 = AW'(1);

   typedef enum logic [1:0] {HUNT, HI, LO, CHECK} state_t;

   typedef struct packed {
      logic [1:0]  phase;
      logic [15:0] data;
   } entry_t;

   state_t      state;
   state_t      state_nx;
   logic [2:0]  bit_cnt;
   logic [1:0]  word_idx;
   logic [7:0]  hi_byte;
   logic        boundary;
   logic        sync_hit;
   logic        start;
   logic        load_hi;
   logic        push;
   logic        sync_miss;

   entry_t      mem [FIFO_DEPTH];
   entry_t      head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0] count;
   logic        full;
   logic        pop;
   logic        wr_en;
   logic        drop;

   assign boundary = (bit_cnt == 3'd7);
   assign sync_hit = (window_in == SYNC_BYTE);
   assign locked   = (state != HUNT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= HUNT;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         HUNT:  if (sync_hit) state_nx = HI;
         HI:    if (boundary) state_nx = LO;
         LO:    if (boundary) state_nx = (word_idx == LAST) ? CHECK : HI;
         CHECK: if (boundary) state_nx = sync_hit ? HI : HUNT;
         default: state_nx = HUNT;
      endcase
   end

   always_comb begin
      start     = 1'b0;
      load_hi   = 1'b0;
      push      = 1'b0;
      sync_miss = 1'b0;
      unique case (state)
         HUNT:  start   = sync_hit;
         HI:    load_hi = boundary;
         LO:    push    = boundary;
         CHECK: begin
            start     = boundary && sync_hit;
            sync_miss = boundary && !sync_hit;
         end
         default: ;
      endcase
   end

   // bit_cnt is 3 bits, so it wraps to 0 on each byte boundary by itself
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt  <= '0;
         word_idx <= '0;
         hi_byte  <= '0;
         sync_err <= 1'b0;
      end else begin
         sync_err <= sync_miss;
         if (start) begin
            bit_cnt  <= '0;
            word_idx <= '0;
         end else if (state != HUNT) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (push && word_idx != LAST) word_idx <= word_idx + 2'd1;
         end
         if (load_hi) hi_byte <= window_in;
      end
   end

   assign full  = (count == FULL);
   assign pop   = frm.out_valid && frm.out_ready;
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= '{phase: word_idx, data: {hi_byte, window_in}};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_1;
         if (pop)   rd_ptr <= rd_ptr + PTR_1;
         unique case ({wr_en, pop})
            2'b10:   count <= count + CNT_1;
            2'b01:   count <= count - CNT_1;
            default: ;
         endcase
         if (drop) overflow <= 1'b1;
      end
   end

   // Stale slots are masked so an empty FIFO presents zeros
   assign head          = mem[rd_ptr];
   assign frm.out_valid = (count != '0);
   assign frm.out_data  = frm.out_valid ? head.data  : 16'h0000;
   assign frm.out_phase = frm.out_valid ? head.phase : 2'd0;

endmodule

// File: tb/tb_serial_frame_decoder.sv
// Directed bench for serial_frame_decoder driven by a
// bit-serial shift-register model.
module tb_serial_frame_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [8:1] win = '0;
   logic       locked;
   logic       sync_err;
   logic       overflow;

   serial_frame_decoder_if bus ();

   serial_frame_decoder dut (
      .clk       (clk),
      .reset     (reset),
      .window_in (win),
      .frm       (bus),
      .locked    (locked),
      .sync_err  (sync_err),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int cnt = 0;
   always @(posedge clk) cnt <= cnt + 1;

   typedef struct {
      logic [15:0] d;
      logic [1:0]  p;
      int          c;
   } obs_t;

   typedef struct {
      logic [15:0] d;
      logic [1:0]  p;
      int          base;
      int          off;
   } vec_t;

   obs_t got[$];
   int   lock_q[$];
   int   err_q[$];
   vec_t exp_q[$];
   int   marks[2];
   logic lock_d = 1'b0;
   logic ready_base = 1'b0;
   int   pulse_cnt = -1;
   int   n_chk = 0;
   int   n_pass = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.out_valid && bus.out_ready)
            got.push_back('{bus.out_data, bus.out_phase, cnt});
         if (sync_err) err_q.push_back(cnt);
         if (locked && !lock_d) lock_q.push_back(cnt);
      end
      lock_d <= locked;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   task automatic shift_bit(input logic b);
      @(posedge clk);
      #1;
      win = {win[7:1], b};
      bus.out_ready = (cnt == pulse_cnt) ? 1'b1 : ready_base;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) shift_bit(b[i]);
   endtask

   task automatic send_word(input logic [15:0] w);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) shift_bit(1'b0);
   endtask

   // window now shows the sync byte; the next edge samples it
   task automatic mark(input int idx);
      @(negedge clk);
      marks[idx] = cnt + 1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      win = '0;
      bus.out_ready = 1'b0;
      ready_base = 1'b0;
      pulse_cnt = -1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      got.delete();
      lock_q.delete();
      err_q.delete();
      exp_q.delete();
   endtask

   task automatic check_outs_zero(input string tag);
      chk({tag, " out_valid"}, bus.out_valid, 0);
      chk({tag, " out_data"}, bus.out_data, 0);
      chk({tag, " out_phase"}, bus.out_phase, 0);
      chk({tag, " locked"}, locked, 0);
      chk({tag, " sync_err"}, sync_err, 0);
      chk({tag, " overflow"}, overflow, 0);
   endtask

   task automatic check_words(input string tag);
      chk({tag, " word count"}, got.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i < got.size()) begin
            chk($sformatf("%s w%0d data", tag, i), got[i].d, exp_q[i].d);
            chk($sformatf("%s w%0d phase", tag, i), got[i].p, exp_q[i].p);
            if (exp_q[i].base >= 0)
               chk($sformatf("%s w%0d cycle", tag, i), got[i].c,
                   marks[exp_q[i].base] + exp_q[i].off);
         end
      end
   endtask

   initial begin
      vec_t ta[9] = '{
         '{16'h1234, 2'd0, 0, 16},  '{16'h5678, 2'd1, 0, 32},
         '{16'h9ABC, 2'd2, 0, 48},  '{16'h1111, 2'd0, 0, 72},
         '{16'h2222, 2'd1, 0, 88},  '{16'h3333, 2'd2, 0, 104},
         '{16'h4444, 2'd0, 1, 16},  '{16'h5555, 2'd1, 1, 32},
         '{16'h6666, 2'd2, 1, 48}};
      vec_t tb_[3] = '{
         '{16'hCAFE, 2'd0, 0, 16},  '{16'h0F0F, 2'd1, 0, 32},
         '{16'h8001, 2'd2, 0, 48}};
      vec_t tc[4] = '{
         '{16'h1234, 2'd0, -1, 0},  '{16'h5678, 2'd1, -1, 0},
         '{16'h9ABC, 2'd2, -1, 0},  '{16'h1111, 2'd0, -1, 0}};
      vec_t td[6] = '{
         '{16'h1234, 2'd0, 0, 87},  '{16'h5678, 2'd1, 0, 96},
         '{16'h9ABC, 2'd2, 0, 97},  '{16'h1111, 2'd0, 0, 98},
         '{16'h2222, 2'd1, 0, 99},  '{16'h3333, 2'd2, 0, 104}};
      vec_t te[3] = '{
         '{16'h0102, 2'd0, 0, 16},  '{16'h0304, 2'd1, 0, 32},
         '{16'h0506, 2'd2, 0, 48}};

      bus.out_ready = 1'b0;
      #2 reset = 1'b1;
      #1 check_outs_zero("reset");

      // stream with a good resync, then a bad sync and re-acquire
      do_reset();
      ready_base = 1'b1;
      idle(3);
      send_byte(8'hA5);
      mark(0);
      chk("locked before sync", locked, 0);
      send_word(16'h1234);
      send_word(16'h5678);
      send_word(16'h9ABC);
      send_byte(8'hA5);
      send_word(16'h1111);
      send_word(16'h2222);
      send_word(16'h3333);
      send_byte(8'h00);
      idle(6);
      send_byte(8'hA5);
      mark(1);
      send_word(16'h4444);
      send_word(16'h5555);
      send_word(16'h6666);
      send_byte(8'h00);
      idle(20);
      foreach (ta[i]) exp_q.push_back(ta[i]);
      check_words("stream");
      chk("lock rises", lock_q.size(), 2);
      if (lock_q.size() == 2) begin
         chk("lock rise 0 cycle", lock_q[0], marks[0] + 1 - 1);
         chk("lock rise 1 cycle", lock_q[1], marks[1]);
      end
      chk("sync_err pulses", err_q.size(), 2);
      if (err_q.size() == 2) begin
         chk("sync_err 0 cycle", err_q[0], marks[0] + 112);
         chk("sync_err 1 cycle", err_q[1], marks[1] + 56);
      end
      chk("unlocked after miss", locked, 0);
      chk("no overflow stream", overflow, 0);

      // random prefix, sync at an odd bit offset
      do_reset();
      ready_base = 1'b1;
      for (int i = 0; i < 13; i++) begin
         logic b;
         b = 1'($urandom_range(0, 1));
         if ({win[7:1], b} == 8'hA5) b = ~b;
         shift_bit(b);
      end
      idle(8);
      chk("no words before sync", got.size(), 0);
      chk("no lock before sync", lock_q.size(), 0);
      send_byte(8'hA5);
      mark(0);
      send_word(16'hCAFE);
      send_word(16'h0F0F);
      send_word(16'h8001);
      send_byte(8'h00);
      idle(20);
      foreach (tb_[i]) exp_q.push_back(tb_[i]);
      check_words("offset");
      chk("offset sync_err", err_q.size(), 1);
      if (err_q.size() == 1)
         chk("offset sync_err cycle", err_q[0], marks[0] + 56);

      // consumer stalled across two frames
      do_reset();
      send_byte(8'hA5);
      mark(0);
      send_word(16'h1234);
      send_word(16'h5678);
      send_word(16'h9ABC);
      send_byte(8'hA5);
      send_word(16'h1111);
      send_byte(8'h22);
      @(negedge clk);
      chk("full no overflow yet", overflow, 0);
      chk("full out_valid", bus.out_valid, 1);
      chk("stall head data", bus.out_data, 16'h1234);
      chk("stall head phase", bus.out_phase, 0);
      send_byte(8'h22);
      send_word(16'h3333);
      send_byte(8'h00);
      idle(4);
      chk("overflow set", overflow, 1);
      chk("stall head held", bus.out_data, 16'h1234);
      ready_base = 1'b1;
      idle(12);
      chk("overflow sticky", overflow, 1);
      chk("drained", bus.out_valid, 0);
      foreach (tc[i]) exp_q.push_back(tc[i]);
      check_words("overflow");

      // pop coincides with a push into a full FIFO
      do_reset();
      send_byte(8'hA5);
      mark(0);
      pulse_cnt = marks[0] + 87;
      send_word(16'h1234);
      send_word(16'h5678);
      send_word(16'h9ABC);
      send_byte(8'hA5);
      send_word(16'h1111);
      send_word(16'h2222);
      send_byte(8'h33);
      @(negedge clk);
      chk("pulse no overflow", overflow, 0);
      chk("pulse head data", bus.out_data, 16'h5678);
      ready_base = 1'b1;
      send_byte(8'h33);
      @(negedge clk);
      chk("four entries drained", bus.out_valid, 0);
      pulse_cnt = -1;
      send_byte(8'h00);
      idle(12);
      chk("pulse overflow final", overflow, 0);
      foreach (td[i]) exp_q.push_back(td[i]);
      check_words("pulse");

      // asynchronous reset in the middle of word 1
      do_reset();
      send_byte(8'hA5);
      mark(0);
      send_word(16'h1234);
      send_byte(8'h56);
      shift_bit(1'b0);
      shift_bit(1'b1);
      shift_bit(1'b1);
      shift_bit(1'b1);
      @(negedge clk);
      chk("pre-reset valid", bus.out_valid, 1);
      chk("pre-reset locked", locked, 1);
      reset = 1'b1;
      #1 check_outs_zero("async reset");
      do_reset();
      ready_base = 1'b1;
      idle(2);
      send_byte(8'hA5);
      mark(0);
      send_word(16'h0102);
      send_word(16'h0304);
      send_word(16'h0506);
      send_byte(8'h00);
      idle(20);
      foreach (te[i]) exp_q.push_back(te[i]);
      check_words("after reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
